// File: rtl/brainfuck_core.sv
// brainfuck_core: multi-cycle Brainfuck interpreter core.
// Fetches instruction bytes from an external code ROM and operates on an
// external byte-wide data RAM; both memories have a one-cycle registered read.
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous active-low reset
//   code           instruction byte, valid one cycle after addr_code
//   addr_code      program counter to the code ROM
//   data_in        cell value, valid one cycle after addr_array
//   addr_array     data pointer (RAM read and write address)
//   done           program finished (sticky until reset)
//   data_out       value written to RAM at addr_array
//   write_rq       RAM write enable, one-cycle pulse
//   receivingChar  input character valid strobe
//   receivedChar   input character
//   sendingChar    output character valid, one-cycle pulse
//   sendedChar     output character, held until the next '.'
module brainfuck_core #(
    parameter int unsigned ARRAY_AW = 5,
    parameter int unsigned CODE_AW  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          code,
    output logic [CODE_AW-1:0]  addr_code,
    input  logic [7:0]          data_in,
    output logic [ARRAY_AW-1:0] addr_array,
    output logic                done,
    output logic [7:0]          data_out,
    output logic                write_rq,
    input  logic                receivingChar,
    input  logic [7:0]          receivedChar,
    output logic                sendingChar,
    output logic [7:0]          sendedChar
);

    localparam int unsigned DEPTH_W = CODE_AW + 1;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;
    localparam logic [7:0] OP_END   = 8'h00;

    typedef enum logic [3:0] {
        S_FETCH,
        S_WAIT_CODE,
        S_EXEC,
        S_WAIT_DATA,
        S_WRITE,
        S_IN_WAIT,
        S_SCAN_FWD,
        S_SCAN_BACK,
        S_HALT
    } state_t;

    state_t               state;
    logic [CODE_AW-1:0]   pc;
    logic [DEPTH_W-1:0]   depth;
    // Scan sub-phase: 0 = address just presented, 1 = code byte valid.
    logic                 scan_ph;

    // The program counter register drives the ROM address directly.
    assign addr_code = pc;

    // Single-process control: state, pointers and all outputs are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH;
            pc          <= '0;
            depth       <= '0;
            scan_ph     <= 1'b0;
            addr_array  <= '0;
            data_out    <= 8'h00;
            write_rq    <= 1'b0;
            done        <= 1'b0;
            sendingChar <= 1'b0;
            sendedChar  <= 8'h00;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            write_rq    <= 1'b0;
            sendingChar <= 1'b0;

            case (state)
                // pc is stable on addr_code this cycle; ROM captures it.
                S_FETCH: begin
                    state <= S_WAIT_CODE;
                end

                S_WAIT_CODE: begin
                    state <= S_EXEC;
                end

                S_EXEC: begin
                    case (code)
                        OP_INC: begin
                            data_out <= data_in + 8'd1;
                            write_rq <= 1'b1;
                            pc       <= pc + CODE_AW'(1);
                            state    <= S_WRITE;
                        end
                        OP_DEC: begin
                            data_out <= data_in - 8'd1;
                            write_rq <= 1'b1;
                            pc       <= pc + CODE_AW'(1);
                            state    <= S_WRITE;
                        end
                        OP_RIGHT: begin
                            addr_array <= addr_array + ARRAY_AW'(1);
                            pc         <= pc + CODE_AW'(1);
                            state      <= S_WAIT_DATA;
                        end
                        OP_LEFT: begin
                            addr_array <= addr_array - ARRAY_AW'(1);
                            pc         <= pc + CODE_AW'(1);
                            state      <= S_WAIT_DATA;
                        end
                        OP_OUT: begin
                            sendedChar  <= data_in;
                            sendingChar <= 1'b1;
                            pc          <= pc + CODE_AW'(1);
                            state       <= S_FETCH;
                        end
                        OP_IN: begin
                            state <= S_IN_WAIT;
                        end
                        OP_OPEN: begin
                            pc <= pc + CODE_AW'(1);
                            if (data_in == 8'h00) begin
                                depth   <= '0;
                                scan_ph <= 1'b0;
                                state   <= S_SCAN_FWD;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                        OP_CLOSE: begin
                            if (data_in != 8'h00) begin
                                pc      <= pc - CODE_AW'(1);
                                depth   <= '0;
                                scan_ph <= 1'b0;
                                state   <= S_SCAN_BACK;
                            end else begin
                                pc    <= pc + CODE_AW'(1);
                                state <= S_FETCH;
                            end
                        end
                        OP_END: begin
                            done  <= 1'b1;
                            state <= S_HALT;
                        end
                        default: begin
                            pc    <= pc + CODE_AW'(1);
                            state <= S_FETCH;
                        end
                    endcase
                end

                // write_rq is high during this cycle; RAM commits at its end.
                S_WRITE: begin
                    state <= S_WAIT_DATA;
                end

                // Lets the RAM re-read the cell after a write or pointer move.
                S_WAIT_DATA: begin
                    state <= S_FETCH;
                end

                S_IN_WAIT: begin
                    if (receivingChar) begin
                        data_out <= receivedChar;
                        write_rq <= 1'b1;
                        pc       <= pc + CODE_AW'(1);
                        state    <= S_WRITE;
                    end
                end

                // Forward search for the matching ']', two cycles per byte.
                S_SCAN_FWD: begin
                    if (!scan_ph) begin
                        scan_ph <= 1'b1;
                    end else begin
                        scan_ph <= 1'b0;
                        pc      <= pc + CODE_AW'(1);
                        if (code == OP_OPEN) begin
                            depth <= depth + DEPTH_W'(1);
                        end else if (code == OP_CLOSE) begin
                            if (depth == '0) begin
                                state <= S_FETCH;
                            end else begin
                                depth <= depth - DEPTH_W'(1);
                            end
                        end
                    end
                end

                // Backward search for the matching '['; resume just after it.
                S_SCAN_BACK: begin
                    if (!scan_ph) begin
                        scan_ph <= 1'b1;
                    end else begin
                        scan_ph <= 1'b0;
                        if (code == OP_CLOSE) begin
                            depth <= depth + DEPTH_W'(1);
                            pc    <= pc - CODE_AW'(1);
                        end else if (code == OP_OPEN) begin
                            if (depth == '0) begin
                                pc    <= pc + CODE_AW'(1);
                                state <= S_FETCH;
                            end else begin
                                depth <= depth - DEPTH_W'(1);
                                pc    <= pc - CODE_AW'(1);
                            end
                        end else begin
                            pc <= pc - CODE_AW'(1);
                        end
                    end
                end

                S_HALT: begin
                    done <= 1'b1;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brainfuck_core.sv
// tb_brainfuck_core: directed programs run against brainfuck_core with a
// code ROM and data RAM modelled in the bench, checked against a plain
// Brainfuck interpreter that predicts output characters, RAM writes and
// the final data array.
module tb_brainfuck_core;

    localparam int CELLS = 32;
    localparam int CODES = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] code;
    logic [4:0] addr_code;
    logic [7:0] data_in;
    logic [4:0] addr_array;
    logic       done;
    logic [7:0] data_out;
    logic       write_rq;
    logic       receivingChar;
    logic [7:0] receivedChar;
    logic       sendingChar;
    logic [7:0] sendedChar;

    logic [7:0] rom [0:CODES-1];
    logic [7:0] ram [0:CELLS-1];
    logic       ram_clr;

    logic [7:0]  m_mem [0:CELLS-1];
    int          m_ptr;
    logic [7:0]  exp_out [$];
    logic [12:0] exp_wr  [$];

    int   checks = 0;
    int   errors = 0;
    logic mon_en;
    logic done_seen;
    int   out_cnt;
    int   wr_cnt;

    always #5 clk = ~clk;

    brainfuck_core #(.ARRAY_AW(5), .CODE_AW(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .code         (code),
        .addr_code    (addr_code),
        .data_in      (data_in),
        .addr_array   (addr_array),
        .done         (done),
        .data_out     (data_out),
        .write_rq     (write_rq),
        .receivingChar(receivingChar),
        .receivedChar (receivedChar),
        .sendingChar  (sendingChar),
        .sendedChar   (sendedChar)
    );

    // Registered-read code ROM.
    always @(posedge clk) code <= rom[addr_code];

    // Registered-read data RAM, read-before-write, with a bench clear.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < CELLS; i++) ram[i] <= 8'h00;
        end else if (write_rq) begin
            ram[addr_array] <= data_out;
        end
        data_in <= ram[addr_array];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic load(input string p);
        for (int i = 0; i < CODES; i++)
            rom[i] = (i < p.len()) ? 8'(p[i]) : 8'h00;
    endtask

    // Reference interpreter over the ROM contents.
    task automatic model_run(input logic [7:0] inb);
        int pc;
        int ptr;
        int depth;
        logic [7:0] c;
        pc  = 0;
        ptr = 0;
        for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h00;
        exp_out.delete();
        exp_wr.delete();
        for (int steps = 0; steps < 20000; steps++) begin
            c = rom[pc];
            if (c == 8'h00) break;
            case (c)
                8'h2B: begin m_mem[ptr] = m_mem[ptr] + 8'd1; exp_wr.push_back({5'(ptr), m_mem[ptr]}); end
                8'h2D: begin m_mem[ptr] = m_mem[ptr] - 8'd1; exp_wr.push_back({5'(ptr), m_mem[ptr]}); end
                8'h3E: ptr = (ptr + 1) % CELLS;
                8'h3C: ptr = (ptr + CELLS - 1) % CELLS;
                8'h2E: exp_out.push_back(m_mem[ptr]);
                8'h2C: begin m_mem[ptr] = inb; exp_wr.push_back({5'(ptr), m_mem[ptr]}); end
                8'h5B: if (m_mem[ptr] == 8'h00) begin
                    depth = 1;
                    for (int k = 0; k < CODES && depth > 0; k++) begin
                        pc = (pc + 1) % CODES;
                        if (rom[pc] == 8'h5B) depth++;
                        else if (rom[pc] == 8'h5D) depth--;
                    end
                end
                8'h5D: if (m_mem[ptr] != 8'h00) begin
                    depth = 1;
                    for (int k = 0; k < CODES && depth > 0; k++) begin
                        pc = (pc + CODES - 1) % CODES;
                        if (rom[pc] == 8'h5D) depth++;
                        else if (rom[pc] == 8'h5B) depth--;
                    end
                end
                default: ;
            endcase
            pc = (pc + 1) % CODES;
        end
        m_ptr = ptr;
    endtask

    task automatic check_reset(input string name);
        check({name, "_addr_code"},   32'(addr_code),   32'h0);
        check({name, "_addr_array"},  32'(addr_array),  32'h0);
        check({name, "_data_out"},    32'(data_out),    32'h0);
        check({name, "_write_rq"},    32'(write_rq),    32'h0);
        check({name, "_done"},        32'(done),        32'h0);
        check({name, "_sendingChar"}, 32'(sendingChar), 32'h0);
        check({name, "_sendedChar"},  32'(sendedChar),  32'h0);
    endtask

    task automatic start_test(input string name, input string p, input logic [7:0] inb);
        mon_en        = 1'b0;
        reset         = 1'b0;
        receivingChar = 1'b0;
        receivedChar  = 8'h00;
        load(p);
        model_run(inb);
        ram_clr = 1'b1;
        repeat (2) @(negedge clk);
        ram_clr = 1'b0;
        check_reset({name, "_rst"});
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_reached"}, 32'(done), 32'h1);
    endtask

    task automatic finish_test(input string name);
        int bad;
        repeat (6) @(negedge clk);
        check({name, "_outs_left"},   32'(exp_out.size()), 32'h0);
        check({name, "_writes_left"}, 32'(exp_wr.size()),  32'h0);
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== m_mem[i]) bad++;
        check({name, "_cells_wrong"}, 32'(bad), 32'h0);
        check({name, "_ptr"}, 32'(addr_array), 32'(m_ptr));
    endtask

    // Per-cycle comparison of strobes against the model's predicted streams.
    task automatic compare_cycle();
        logic [7:0]  e;
        logic [12:0] w;
        if (!mon_en) begin
            done_seen = 1'b0;
            out_cnt   = 0;
            wr_cnt    = 0;
        end else begin
            check("strobe_exclusive", 32'(write_rq & sendingChar), 32'h0);
            if (sendingChar) begin
                out_cnt++;
                if (exp_out.size() == 0) begin
                    check("unexpected_output", 32'(sendingChar), 32'h0);
                end else begin
                    e = exp_out.pop_front();
                    check("sendedChar", 32'(sendedChar), 32'(e));
                end
            end
            if (write_rq) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(write_rq), 32'h0);
                end else begin
                    w = exp_wr.pop_front();
                    check("ram_write", 32'({addr_array, data_out}), 32'(w));
                end
            end
            if (done_seen) check("done_held", 32'(done), 32'h1);
            if (done) done_seen = 1'b1;
        end
    endtask

    initial begin
        mon_en        = 1'b0;
        reset         = 1'b0;
        ram_clr       = 1'b1;
        receivingChar = 1'b0;
        receivedChar  = 8'h00;
        for (int i = 0; i < CODES; i++) rom[i] = 8'h00;

        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Counting, with a stray input strobe that must be ignored.
        start_test("t1", "+++.", 8'h00);
        repeat (3) @(negedge clk);
        receivedChar  = 8'h55;
        receivingChar = 1'b1;
        @(negedge clk);
        receivingChar = 1'b0;
        wait_done("t1", 500);
        finish_test("t1");
        check("t1_sendedChar_lit", 32'(sendedChar), 32'h03);

        // Input stall: nothing happens until the strobe arrives.
        start_test("t2", ",.", 8'h20);
        repeat (1500) @(negedge clk);
        check("t2_stall_outputs", 32'(out_cnt), 32'h0);
        check("t2_stall_writes",  32'(wr_cnt),  32'h0);
        check("t2_stall_done",    32'(done),    32'h0);
        receivedChar  = 8'h20;
        receivingChar = 1'b1;
        #100;
        receivingChar = 1'b0;
        wait_done("t2", 500);
        finish_test("t2");
        check("t2_out_count", 32'(out_cnt), 32'h1);
        check("t2_sendedChar_lit", 32'(sendedChar), 32'h20);

        // Loop moving a value between cells.
        start_test("t3", "++[->+<]>.", 8'h00);
        wait_done("t3", 2000);
        finish_test("t3");
        check("t3_sendedChar_lit", 32'(sendedChar), 32'h02);
        check("t3_cell0_lit", 32'(ram[0]), 32'h00);
        check("t3_cell1_lit", 32'(ram[1]), 32'h02);

        // Pointer and value wrap-around.
        start_test("t4", "<-.", 8'h00);
        wait_done("t4", 500);
        finish_test("t4");
        check("t4_addr_array_lit", 32'(addr_array), 32'd31);
        check("t4_sendedChar_lit", 32'(sendedChar), 32'hFF);

        // Nested forward skip with unknown bytes.
        start_test("t5", "[+a[+]]a.", 8'h00);
        wait_done("t5", 500);
        finish_test("t5");
        check("t5_sendedChar_lit", 32'(sendedChar), 32'h00);
        check("t5_cell0_lit", 32'(ram[0]), 32'h00);

        // Nested loops exercising backward scans.
        start_test("t6", "++[>++[>+<-]<-]>>.", 8'h00);
        wait_done("t6", 5000);
        finish_test("t6");
        check("t6_sendedChar_lit", 32'(sendedChar), 32'h04);

        // Reset asserted mid forward scan.
        start_test("t7", ">+.<[+++++++]+.", 8'h00);
        begin
            int n;
            n = 0;
            while (out_cnt == 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("t7_first_out", 32'(out_cnt), 32'h1);
        repeat (10) @(negedge clk);
        check("t7_pre_sendedChar", 32'(sendedChar), 32'h01);
        check("t7_pre_data_out", 32'(data_out), 32'h01);
        check("t7_pre_pc_nonzero", 32'(addr_code != 5'd0), 32'h1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_reset("t7_midscan");
        model_run(8'h00);
        ram_clr = 1'b1;
        repeat (2) @(negedge clk);
        ram_clr = 1'b0;
        check_reset("t7_held");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("t7_restart_pc", 32'(addr_code), 32'h0);
        wait_done("t7", 1000);
        finish_test("t7");
        check("t7_out_count", 32'(out_cnt), 32'h2);
        check("t7_sendedChar_lit", 32'(sendedChar), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
